// File: rtl/du_sequencer_if.sv
// du_sequencer_if: byte link, transmit handshake and pipeline debug-port
// signals between the debug-unit sequencer and its surroundings.
// master: the sequencer side. slave: the link wrappers / pipeline side.
interface du_sequencer_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        i_tx_ready;
  logic [31:0] o_du_data;
  logic [31:0] o_du_inst_addr_wr;
  logic        o_du_write_en;
  logic        o_du_read_en;
  logic [31:0] o_du_reg_addr;
  logic [31:0] o_du_mem_addr;
  logic        i_du_halt;
  logic [31:0] i_du_regs_mem_data;
  logic [31:0] i_du_mem_data;

  modport master (
    input  i_rx_data, i_rx_valid, i_tx_ready, i_du_halt,
           i_du_regs_mem_data, i_du_mem_data,
    output o_tx_data, o_tx_valid, o_du_data, o_du_inst_addr_wr,
           o_du_write_en, o_du_read_en, o_du_reg_addr, o_du_mem_addr
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_tx_ready, i_du_halt,
           i_du_regs_mem_data, i_du_mem_data,
    input  o_tx_data, o_tx_valid, o_du_data, o_du_inst_addr_wr,
           o_du_write_en, o_du_read_en, o_du_reg_addr, o_du_mem_addr
  );
endinterface

// File: rtl/du_sequencer.sv
// du_sequencer: debug-unit command sequencer. Decodes LOAD/RUN/STEP/DUMP
// command bytes from a byte link, writes program words into instruction
// memory, advances the pipeline, and streams registers and data memory back.
// Optional macro DU_CYCLE_COUNT_EN: counts pipeline-advance cycles and sends
// the count as a 4-byte prefix to every DUMP.
module du_sequencer #(
  parameter int REG_COUNT      = 32,
  parameter int MEM_DUMP_WORDS = 32
) (
  input logic             i_clk,
  input logic             i_reset,
  du_sequencer_if.master  du_if
);
  localparam int MAXN  = (REG_COUNT > MEM_DUMP_WORDS) ? REG_COUNT : MEM_DUMP_WORDS;
  localparam int IDX_W = (MAXN > 1) ? $clog2(MAXN) : 1;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_RUN  = 8'h02;
  localparam logic [7:0] CMD_STEP = 8'h03;
  localparam logic [7:0] CMD_DUMP = 8'h04;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_HALT = 8'h48;
  localparam logic [7:0] RSP_STEP = 8'h53;

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WR, RUN, STEP, RD_ADDR, RD_CAP, TX_WORD, TX_BYTE
  } state_t;

  state_t           state_q;
  logic [7:0]       tx_data_q;
  logic             tx_valid_q;
  logic [31:0]      du_data_q;
  logic [31:0]      inst_addr_q;
  logic             write_en_q;
  logic [31:0]      reg_addr_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      word_q;
  logic [1:0]       byte_cnt_q;
  logic [7:0]       n_q;
  logic [7:0]       k_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             mem_ph_q;
  logic             dump_q;
  logic             tx_done;
  logic             read_en;
`ifdef DU_CYCLE_COUNT_EN
  logic [31:0]      cyc_cnt_q;
  logic             cnt_ph_q;
`endif

  // Advance enable is gated combinationally by halt so the halting cycle never advances.
  always_comb begin
    idx_d   = idx_q + IDX_W'(1);
    read_en = ((state_q == RUN) || (state_q == STEP)) && !du_if.i_du_halt;
    tx_done = tx_valid_q && du_if.i_tx_ready;
  end

  assign du_if.o_tx_data         = tx_data_q;
  assign du_if.o_tx_valid        = tx_valid_q;
  assign du_if.o_du_data         = du_data_q;
  assign du_if.o_du_inst_addr_wr = inst_addr_q;
  assign du_if.o_du_write_en     = write_en_q;
  assign du_if.o_du_read_en      = read_en;
  assign du_if.o_du_reg_addr     = reg_addr_q;
  assign du_if.o_du_mem_addr     = mem_addr_q;

  // Command FSM with registered outputs; write strobe defaults low each cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      du_data_q   <= '0;
      inst_addr_q <= '0;
      write_en_q  <= 1'b0;
      reg_addr_q  <= '0;
      mem_addr_q  <= '0;
      word_q      <= '0;
      byte_cnt_q  <= '0;
      n_q         <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      mem_ph_q    <= 1'b0;
      dump_q      <= 1'b0;
`ifdef DU_CYCLE_COUNT_EN
      cnt_ph_q    <= 1'b0;
`endif
    end else begin
      write_en_q <= 1'b0;
      case (state_q)
        IDLE: if (du_if.i_rx_valid) begin
          case (du_if.i_rx_data)
            CMD_LOAD: state_q <= LD_CNT;
            CMD_RUN:  state_q <= RUN;
            CMD_STEP: state_q <= STEP;
            CMD_DUMP: begin
              dump_q   <= 1'b1;
              mem_ph_q <= 1'b0;
              idx_q    <= '0;
`ifdef DU_CYCLE_COUNT_EN
              word_q   <= cyc_cnt_q;
              cnt_ph_q <= 1'b1;
              state_q  <= TX_WORD;
`else
              reg_addr_q <= '0;
              state_q    <= RD_ADDR;
`endif
            end
            default: begin
              tx_data_q  <= RSP_NAK;
              tx_valid_q <= 1'b1;
              state_q    <= TX_BYTE;
            end
          endcase
        end
        LD_CNT: if (du_if.i_rx_valid) begin
          n_q        <= du_if.i_rx_data;
          k_q        <= '0;
          byte_cnt_q <= '0;
          if (du_if.i_rx_data == 8'd0) begin
            tx_data_q  <= RSP_ACK;
            tx_valid_q <= 1'b1;
            state_q    <= TX_BYTE;
          end else begin
            state_q <= LD_BYTE;
          end
        end
        LD_BYTE: if (du_if.i_rx_valid) begin
          du_data_q <= {du_data_q[23:0], du_if.i_rx_data};
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_q  <= '0;
            write_en_q  <= 1'b1;
            inst_addr_q <= {22'd0, k_q, 2'b00};
            state_q     <= LD_WR;
          end else begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        LD_WR: begin
          if (k_q == n_q - 8'd1) begin
            tx_data_q  <= RSP_ACK;
            tx_valid_q <= 1'b1;
            state_q    <= TX_BYTE;
          end else begin
            k_q     <= k_q + 8'd1;
            state_q <= LD_BYTE;
          end
        end
        RUN: if (du_if.i_du_halt) begin
          tx_data_q  <= RSP_HALT;
          tx_valid_q <= 1'b1;
          state_q    <= TX_BYTE;
        end
        STEP: begin
          tx_data_q  <= du_if.i_du_halt ? RSP_HALT : RSP_STEP;
          tx_valid_q <= 1'b1;
          state_q    <= TX_BYTE;
        end
        RD_ADDR: state_q <= RD_CAP;
        RD_CAP: begin
          word_q  <= mem_ph_q ? du_if.i_du_mem_data : du_if.i_du_regs_mem_data;
          state_q <= TX_WORD;
        end
        TX_WORD: begin
          tx_data_q  <= word_q[31:24];
          word_q     <= {word_q[23:0], 8'h00};
          byte_cnt_q <= '0;
          tx_valid_q <= 1'b1;
          state_q    <= TX_BYTE;
        end
        TX_BYTE: if (tx_done) begin
          if (dump_q && byte_cnt_q != 2'd3) begin
            tx_data_q  <= word_q[31:24];
            word_q     <= {word_q[23:0], 8'h00};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end else begin
            tx_valid_q <= 1'b0;
            if (!dump_q) begin
              state_q <= IDLE;
            end else
`ifdef DU_CYCLE_COUNT_EN
            if (cnt_ph_q) begin
              cnt_ph_q   <= 1'b0;
              reg_addr_q <= '0;
              state_q    <= RD_ADDR;
            end else
`endif
            if (!mem_ph_q) begin
              if (idx_q == IDX_W'(REG_COUNT - 1)) begin
                mem_ph_q   <= 1'b1;
                idx_q      <= '0;
                mem_addr_q <= '0;
              end else begin
                idx_q      <= idx_d;
                reg_addr_q <= 32'(idx_d);
              end
              state_q <= RD_ADDR;
            end else if (idx_q == IDX_W'(MEM_DUMP_WORDS - 1)) begin
              dump_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q      <= idx_d;
              mem_addr_q <= 32'(idx_d) << 2;
              state_q    <= RD_ADDR;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DU_CYCLE_COUNT_EN
  // Saturating count of pipeline-advance cycles, restarted by each LOAD command.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cyc_cnt_q <= '0;
    end else if (state_q == IDLE && du_if.i_rx_valid && du_if.i_rx_data == CMD_LOAD) begin
      cyc_cnt_q <= '0;
    end else if (read_en && cyc_cnt_q != 32'hFFFF_FFFF) begin
      cyc_cnt_q <= cyc_cnt_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_du_sequencer.sv
// tb_du_sequencer: directed + randomized bench for du_sequencer with a
// queue-based reference of expected writes, responses and dump payloads.
module tb_du_sequencer;
  localparam int REG_COUNT = 32;
  localparam int MEM_W     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_ready = 1'b1;
  always #5 clk = ~clk;

  du_sequencer_if bus();
  assign bus.i_tx_ready = tx_ready;

  du_sequencer #(.REG_COUNT(REG_COUNT), .MEM_DUMP_WORDS(MEM_W)) dut (
    .i_clk(clk), .i_reset(rst), .du_if(bus.master)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] regs [REG_COUNT];
  logic [31:0] mem  [MEM_W];
  bit rand_ready = 0;
  logic [7:0]  tx_q [$];
  logic [63:0] wr_q [$];
  int rd_cnt = 0;
  int cyc_base = 0;
  bit both_seen = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;

  // Register file / data memory read model (combinational).
  always_comb begin
    bus.i_du_regs_mem_data = regs[bus.o_du_reg_addr[4:0]];
    bus.i_du_mem_data      = mem[bus.o_du_mem_addr[6:2]];
  end

  always @(posedge clk) begin
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe outputs mid-cycle: these are the values the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) check("tx_hold", {55'd0, bus.o_tx_valid, bus.o_tx_data}, {55'd0, 1'b1, prev_data});
      if (bus.o_tx_valid && tx_ready) tx_q.push_back(bus.o_tx_data);
      if (bus.o_du_write_en) wr_q.push_back({bus.o_du_inst_addr_wr, bus.o_du_data});
      if (bus.o_du_read_en) rd_cnt++;
      if (bus.o_du_write_en && bus.o_du_read_en) both_seen = 1;
      prev_stall = bus.o_tx_valid && !tx_ready;
      prev_data  = bus.o_tx_data;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(posedge clk); c++;
    end
    check(tag, 64'(tx_q.size() >= n), 64'd1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_txv"},  64'(bus.o_tx_valid), 64'd0);
    check({tag, "_txd"},  64'(bus.o_tx_data), 64'd0);
    check({tag, "_data"}, 64'(bus.o_du_data), 64'd0);
    check({tag, "_iadr"}, 64'(bus.o_du_inst_addr_wr), 64'd0);
    check({tag, "_wen"},  64'(bus.o_du_write_en), 64'd0);
    check({tag, "_ren"},  64'(bus.o_du_read_en), 64'd0);
    check({tag, "_radr"}, 64'(bus.o_du_reg_addr), 64'd0);
    check({tag, "_madr"}, 64'(bus.o_du_mem_addr), 64'd0);
  endtask

  task automatic do_load(input logic [31:0] words[$], input string tag);
    int wbase = wr_q.size();
    int tbase = tx_q.size();
    logic [31:0] w;
    send(8'h01);
    cyc_base = rd_cnt;
    send(8'(words.size()));
    foreach (words[k]) begin
      w = words[k];
      for (int b = 3; b >= 0; b--) send(w[8*b +: 8]);
    end
    wait_tx(tbase + 1, 200, {tag, "_ack_wait"});
    check({tag, "_ack"}, 64'(tx_q[tbase]), 64'h06);
    check({tag, "_nwr"}, 64'(wr_q.size() - wbase), 64'(words.size()));
    foreach (words[k])
      check({tag, "_wr"}, wr_q[wbase + k], {32'(4 * k), words[k]});
  endtask

  task automatic do_run(input int n, input string tag);
    int base = rd_cnt;
    int tbase = tx_q.size();
    bus.i_du_halt = (n == 0);
    send(8'h02);
    for (int c = 0; c < 500 && !bus.i_du_halt; c++) begin
      if (rd_cnt - base >= n) bus.i_du_halt = 1'b1;
      else begin @(posedge clk); #1; end
    end
    wait_tx(tbase + 1, 200, {tag, "_wait"});
    check({tag, "_rsp"}, 64'(tx_q[tbase]), 64'h48);
    check({tag, "_cycles"}, 64'(rd_cnt - base), 64'(n));
  endtask

  task automatic do_step(input logic halt, input string tag);
    int base = rd_cnt;
    int tbase = tx_q.size();
    bus.i_du_halt = halt;
    send(8'h03);
    wait_tx(tbase + 1, 200, {tag, "_wait"});
    check({tag, "_rsp"}, 64'(tx_q[tbase]), halt ? 64'h48 : 64'h53);
    check({tag, "_cycles"}, 64'(rd_cnt - base), halt ? 64'd0 : 64'd1);
  endtask

  task automatic do_dump(input string tag);
    logic [7:0] exp [$];
    logic [31:0] w;
    int tbase = tx_q.size();
`ifdef DU_CYCLE_COUNT_EN
    w = 32'(rd_cnt - cyc_base);
    for (int b = 3; b >= 0; b--) exp.push_back(w[8*b +: 8]);
`endif
    for (int r = 0; r < REG_COUNT; r++) begin
      w = regs[r];
      for (int b = 3; b >= 0; b--) exp.push_back(w[8*b +: 8]);
    end
    for (int m = 0; m < MEM_W; m++) begin
      w = mem[m];
      for (int b = 3; b >= 0; b--) exp.push_back(w[8*b +: 8]);
    end
    rand_ready = 1;
    send(8'h04);
    wait_tx(tbase + exp.size(), 20000, {tag, "_wait"});
    repeat (20) @(posedge clk);
    rand_ready = 0;
    check({tag, "_len"}, 64'(tx_q.size() - tbase), 64'(exp.size()));
    foreach (exp[i])
      if (tbase + i < tx_q.size()) check({tag, "_byte"}, {32'(i), 24'd0, tx_q[tbase + i]}, {32'(i), 24'd0, exp[i]});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ws [$];
    int tbase;
    int wbase;
    bus.i_rx_data = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_du_halt = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) regs[i] = '0;
    for (int i = 0; i < MEM_W; i++) mem[i] = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    cyc_base = rd_cnt;

    ws = '{32'h24430001, 32'hAC030004, 32'hFC000000};
    do_load(ws, "load3");
    ws = {};
    do_load(ws, "load0");
    ws = {};
    for (int i = 0; i < 5; i++) ws.push_back($urandom);
    do_load(ws, "loadrnd");

    do_run(7, "run7");
    do_run(0, "run0");
    do_step(1'b0, "step_run");
    do_step(1'b1, "step_halt");

    tbase = tx_q.size();
    send(8'h7F);
    wait_tx(tbase + 1, 200, "nak_wait");
    check("nak", 64'(tx_q[tbase]), 64'h15);
    tbase = tx_q.size();
    send(8'($urandom_range(5, 255)));
    wait_tx(tbase + 1, 200, "nakrnd_wait");
    check("nakrnd", 64'(tx_q[tbase]), 64'h15);

    regs[3] = 32'h00000001;
    mem[1]  = 32'h00000001;
    do_dump("dump_plan");

    for (int i = 0; i < REG_COUNT; i++) regs[i] = $urandom;
    for (int i = 0; i < MEM_W; i++) mem[i] = $urandom;
    do_run($urandom_range(1, 20), "runrnd");
    do_dump("dump_rnd");

    wbase = wr_q.size();
    send(8'h01);
    send(8'h02);
    for (int i = 0; i < 5; i++) send(8'h11 + 8'(i));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero_outputs("midreset");
    rst = 1'b0;
    cyc_base = rd_cnt;
    check("midreset_nwr", 64'(wr_q.size() - wbase), 64'd1);
    check("midreset_wr0", wr_q[wbase], {32'd0, 32'h11121314});
    wbase = wr_q.size();
    do_run(3, "run_after_reset");
    check("run_after_reset_nwr", 64'(wr_q.size() - wbase), 64'd0);
    check("wen_ren_exclusive", 64'(both_seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
